axi_lite_slave: RTL and testbench

AXI4-Lite responder that terminates the `axi_lite_if` slave modport and implements a small memory-mapped register file of 32-bit words. It is the counterpart to the team's AXI-Lite master and sits at the leaf of the interconnect, one per peripheral register bank. The read and write channels run as independent state machines. Writes honour `wstrb`, and out-of-range accesses complete with SLVERR.

---
 rtl/axi_lite_pkg.sv | 38 +++
 rtl/axi_lite_if.sv | 37 +++
 rtl/axi_lite_regfile.sv | 57 +++++
 rtl/axi_lite_slave.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_slave.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register-bank slave.
// Contents:
//   addr_t / data_t / strb_t / resp_t : channel payload types
//   RESP_OKAY / RESP_SLVERR           : B/R response encodings
//   wstate_t / rstate_t               : write and read channel FSM states
//   addr_in_range()                   : true when a byte address falls inside
//                                       a bank of num_regs 32-bit words
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [1:0]        resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // The full address is compared, so any set upper bit lands out of range
  // instead of aliasing onto a low register.
  function automatic logic addr_in_range(input addr_t addr, input int unsigned num_regs);
    return addr < (addr_t'(num_regs) << 2);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle shared by the team's master and slave blocks.
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Modports: master drives the request side, slave drives the response side.
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// Register array behind the AXI4-Lite slave.
// Ports:
//   aclk, areset_n : clock, synchronous active-low reset
//   wr_en, wr_idx, wr_data, wr_strb : single byte-enabled write port
//   rd_en, rd_hit, rd_idx, rd_data  : registered read port; rd_hit=0 loads zero
//   regs_o : flattened contents, reg i at [32*i +: 32]
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 8,
  parameter data_t RESET_VAL = 32'h0,
  localparam int   IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  data_t                    wr_data,
  input  strb_t                    wr_strb,
  input  logic                     rd_en,
  input  logic                     rd_hit,
  input  logic [IDX_W-1:0]         rd_idx,
  output data_t                    rd_data,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  data_t regs [NUM_REGS];

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Samples the array before any same-edge write lands, so a read that
  // collides with a write to the same word returns the old contents.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? regs[rd_idx] : '0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_tap
    assign regs_o[32*g +: 32] = regs[g];
  end

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite responder for one peripheral register bank.
// Ports:
//   aclk, areset_n : clock, synchronous active-low reset
//   s_axi_lite     : axi_lite_if.slave modport (AW/W/B/AR/R)
//   regs_o         : flattened register contents for observation/debug
// Write and read channels run as independent two-state FSMs; all ready/valid
// outputs decode from registered state only.
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 8,
  parameter data_t RESET_VAL = 32'h0
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  axi_lite_if.slave              s_axi_lite,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wstate_t wstate, wstate_next;
  logic    aw_held, aw_held_next;
  logic    w_held, w_held_next;
  addr_t   aw_addr_q;
  data_t   w_data_q;
  strb_t   w_strb_q;
  resp_t   bresp_q, bresp_next;
  logic    aw_ready, w_ready, b_valid;

  rstate_t rstate, rstate_next;
  resp_t   rresp_q, rresp_next;
  logic    ar_ready, r_valid;

  addr_t   wr_addr;
  data_t   wr_data;
  strb_t   wr_strb;
  logic    wr_in_range;
  logic    wr_en;
  logic    rd_en;
  logic    rd_hit;
  data_t   rd_data;

  // A beat that has not been held yet is taken straight from the bus so the
  // commit can happen in the same cycle as the second handshake.
  assign wr_addr     = aw_held ? aw_addr_q : s_axi_lite.awaddr;
  assign wr_data     = w_held  ? w_data_q  : s_axi_lite.wdata;
  assign wr_strb     = w_held  ? w_strb_q  : s_axi_lite.wstrb;
  assign wr_in_range = addr_in_range(wr_addr, NUM_REGS);

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wstate    <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      wstate  <= wstate_next;
      aw_held <= aw_held_next;
      w_held  <= w_held_next;
      bresp_q <= bresp_next;
      if (aw_ready && s_axi_lite.awvalid) begin
        aw_addr_q <= s_axi_lite.awaddr;
      end
      if (w_ready && s_axi_lite.wvalid) begin
        w_data_q <= s_axi_lite.wdata;
        w_strb_q <= s_axi_lite.wstrb;
      end
    end
  end

  // The held_next flags double as "this beat is available now", so the
  // commit test covers both the already-held and same-cycle cases.
  always_comb begin
    wstate_next  = wstate;
    aw_held_next = aw_held;
    w_held_next  = w_held;
    bresp_next   = bresp_q;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    wr_en        = 1'b0;
    case (wstate)
      W_IDLE: begin
        aw_ready = !aw_held;
        w_ready  = !w_held;
        if (aw_ready && s_axi_lite.awvalid) begin
          aw_held_next = 1'b1;
        end
        if (w_ready && s_axi_lite.wvalid) begin
          w_held_next = 1'b1;
        end
        if (aw_held_next && w_held_next) begin
          wr_en       = wr_in_range;
          bresp_next  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (s_axi_lite.bready) begin
          wstate_next  = W_IDLE;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
        end
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  assign s_axi_lite.awready = aw_ready;
  assign s_axi_lite.wready  = w_ready;
  assign s_axi_lite.bvalid  = b_valid;
  assign s_axi_lite.bresp   = bresp_q;

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rstate  <= R_IDLE;
      rresp_q <= RESP_OKAY;
    end else begin
      rstate  <= rstate_next;
      rresp_q <= rresp_next;
    end
  end

  // Read data itself is registered inside the regfile; this FSM only tracks
  // the handshake and the response code.
  always_comb begin
    rstate_next = rstate;
    rresp_next  = rresp_q;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    rd_en       = 1'b0;
    rd_hit      = addr_in_range(s_axi_lite.araddr, NUM_REGS);
    case (rstate)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (s_axi_lite.arvalid) begin
          rd_en       = 1'b1;
          rresp_next  = rd_hit ? RESP_OKAY : RESP_SLVERR;
          rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (s_axi_lite.rready) begin
          rstate_next = R_IDLE;
        end
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  assign s_axi_lite.arready = ar_ready;
  assign s_axi_lite.rvalid  = r_valid;
  assign s_axi_lite.rresp   = rresp_q;
  assign s_axi_lite.rdata   = rd_data;

  axi_lite_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .aclk     (aclk),
    .areset_n (areset_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_addr[2 +: IDX_W]),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_en    (rd_en),
    .rd_hit   (rd_hit),
    .rd_idx   (s_axi_lite.araddr[2 +: IDX_W]),
    .rd_data  (rd_data),
    .regs_o   (regs_o)
  );

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed self-checking bench for axi_lite_slave (NUM_REGS=8, RESET_VAL=0).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_lite_slave;
  import axi_lite_pkg::*;

  localparam int    NUM_REGS  = 8;
  localparam data_t RESET_VAL = 32'h0;
  localparam int    REGS_W    = NUM_REGS * 32;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic [REGS_W-1:0] regs_o;
  logic [REGS_W-1:0] exp_regs;
  int                checks   = 0;
  int                failures = 0;

  axi_lite_if bus ();

  axi_lite_slave #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .s_axi_lite (bus),
    .regs_o     (regs_o)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [REGS_W-1:0] observed,
                              input logic [REGS_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic apply_write(input addr_t a, input data_t d, input strb_t s);
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
  endtask

  task automatic release_write();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic complete_b(input string tag);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check_output({tag, "_bvalid_clr"}, REGS_W'(bus.bvalid), '0);
    check_output({tag, "_awready_back"}, REGS_W'(bus.awready), REGS_W'(1));
  endtask

  task automatic issue_read(input addr_t a);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic complete_r(input string tag);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check_output({tag, "_rvalid_clr"}, REGS_W'(bus.rvalid), '0);
    check_output({tag, "_arready_back"}, REGS_W'(bus.arready), REGS_W'(1));
  endtask

  initial begin
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    areset_n    = 1'b0;
    exp_regs    = '0;

    // Reset state
    repeat (2) tick();
    check_output("rst_awready", REGS_W'(bus.awready), REGS_W'(1));
    check_output("rst_wready",  REGS_W'(bus.wready),  REGS_W'(1));
    check_output("rst_arready", REGS_W'(bus.arready), REGS_W'(1));
    check_output("rst_bvalid",  REGS_W'(bus.bvalid),  '0);
    check_output("rst_rvalid",  REGS_W'(bus.rvalid),  '0);
    check_output("rst_bresp",   REGS_W'(bus.bresp),   '0);
    check_output("rst_rresp",   REGS_W'(bus.rresp),   '0);
    check_output("rst_rdata",   REGS_W'(bus.rdata),   '0);
    check_output("rst_regs",    regs_o,               exp_regs);
    areset_n = 1'b1;
    tick();

    // Basic write, AW and W together
    apply_write(32'h4, 32'hdeadbeef, 4'hF);
    tick();
    release_write();
    exp_regs[63:32] = 32'hdeadbeef;
    check_output("wr1_bvalid",  REGS_W'(bus.bvalid),  REGS_W'(1));
    check_output("wr1_bresp",   REGS_W'(bus.bresp),   REGS_W'(RESP_OKAY));
    check_output("wr1_awready", REGS_W'(bus.awready), '0);
    check_output("wr1_wready",  REGS_W'(bus.wready),  '0);
    check_output("wr1_regs",    regs_o,               exp_regs);
    complete_b("wr1");

    // Read back
    issue_read(32'h4);
    check_output("rd1_rvalid",  REGS_W'(bus.rvalid),  REGS_W'(1));
    check_output("rd1_rdata",   REGS_W'(bus.rdata),   REGS_W'(32'hdeadbeef));
    check_output("rd1_rresp",   REGS_W'(bus.rresp),   REGS_W'(RESP_OKAY));
    check_output("rd1_arready", REGS_W'(bus.arready), '0);
    complete_r("rd1");

    // Strobe handling on reg2
    apply_write(32'h8, 32'h11223344, 4'hF);
    tick();
    release_write();
    exp_regs[95:64] = 32'h11223344;
    check_output("strb_init_regs", regs_o, exp_regs);
    complete_b("strb_init");
    apply_write(32'h8, 32'hAABBCCDD, 4'h5);
    tick();
    release_write();
    exp_regs[95:64] = 32'h11BB33DD;
    check_output("strb5_bresp", REGS_W'(bus.bresp), REGS_W'(RESP_OKAY));
    check_output("strb5_regs",  regs_o,             exp_regs);
    complete_b("strb5");
    apply_write(32'h8, 32'hFFFFFFFF, 4'h0);
    tick();
    release_write();
    check_output("strb0_bvalid", REGS_W'(bus.bvalid), REGS_W'(1));
    check_output("strb0_bresp",  REGS_W'(bus.bresp),  REGS_W'(RESP_OKAY));
    check_output("strb0_regs",   regs_o,              exp_regs);
    complete_b("strb0");

    // W three cycles ahead of AW
    bus.wdata  = 32'h5A5A5A5A;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check_output("ord_wready_drop", REGS_W'(bus.wready),  '0);
    check_output("ord_awready",     REGS_W'(bus.awready), REGS_W'(1));
    tick();
    tick();
    check_output("ord_no_bvalid",   REGS_W'(bus.bvalid),  '0);
    bus.awaddr  = 32'h0;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    exp_regs[31:0] = 32'h5A5A5A5A;
    check_output("ord_bvalid", REGS_W'(bus.bvalid), REGS_W'(1));
    check_output("ord_regs",   regs_o,              exp_regs);
    complete_b("ord");

    // Out-of-range write and read
    apply_write(32'h20, 32'hFFFFFFFF, 4'hF);
    tick();
    release_write();
    check_output("oor_w_bresp", REGS_W'(bus.bresp), REGS_W'(RESP_SLVERR));
    check_output("oor_w_regs",  regs_o,             exp_regs);
    complete_b("oor_w");
    issue_read(32'h3C);
    check_output("oor_r_rvalid", REGS_W'(bus.rvalid), REGS_W'(1));
    check_output("oor_r_rdata",  REGS_W'(bus.rdata),  '0);
    check_output("oor_r_rresp",  REGS_W'(bus.rresp),  REGS_W'(RESP_SLVERR));
    complete_r("oor_r");

    // Preload reg3, then write it while reading it in the same cycle
    apply_write(32'hC, 32'h0BADC0DE, 4'hF);
    tick();
    release_write();
    complete_b("pre3");
    apply_write(32'hC, 32'h12345678, 4'hF);
    bus.araddr  = 32'hC;
    bus.arvalid = 1'b1;
    tick();
    release_write();
    bus.arvalid = 1'b0;
    exp_regs[127:96] = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_bvalid",  REGS_W'(bus.bvalid),  REGS_W'(1));
      check_output("bp_bresp",   REGS_W'(bus.bresp),   REGS_W'(RESP_OKAY));
      check_output("bp_rvalid",  REGS_W'(bus.rvalid),  REGS_W'(1));
      check_output("bp_rdata",   REGS_W'(bus.rdata),   REGS_W'(32'h0BADC0DE));
      check_output("bp_rresp",   REGS_W'(bus.rresp),   REGS_W'(RESP_OKAY));
      check_output("bp_awready", REGS_W'(bus.awready), '0);
      check_output("bp_wready",  REGS_W'(bus.wready),  '0);
      check_output("bp_arready", REGS_W'(bus.arready), '0);
      check_output("bp_regs",    regs_o,               exp_regs);
      tick();
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    check_output("bp_bvalid_clr", REGS_W'(bus.bvalid),  '0);
    check_output("bp_rvalid_clr", REGS_W'(bus.rvalid),  '0);
    check_output("bp_awready_up", REGS_W'(bus.awready), REGS_W'(1));
    check_output("bp_arready_up", REGS_W'(bus.arready), REGS_W'(1));

    // Reset while a write response is pending
    apply_write(32'h10, 32'hCAFEF00D, 4'hF);
    tick();
    release_write();
    check_output("mrst_pre_bvalid", REGS_W'(bus.bvalid), REGS_W'(1));
    areset_n = 1'b0;
    tick();
    exp_regs = '0;
    check_output("mrst_bvalid",  REGS_W'(bus.bvalid),  '0);
    check_output("mrst_regs",    regs_o,               exp_regs);
    check_output("mrst_awready", REGS_W'(bus.awready), REGS_W'(1));
    check_output("mrst_wready",  REGS_W'(bus.wready),  REGS_W'(1));
    check_output("mrst_arready", REGS_W'(bus.arready), REGS_W'(1));
    check_output("mrst_rdata",   REGS_W'(bus.rdata),   '0);
    areset_n = 1'b1;
    tick();
    check_output("mrst_no_resp", REGS_W'(bus.bvalid), '0);
    issue_read(32'h4);
    check_output("mrst_rd_rvalid", REGS_W'(bus.rvalid), REGS_W'(1));
    check_output("mrst_rd_rdata",  REGS_W'(bus.rdata),  REGS_W'(RESET_VAL));
    check_output("mrst_rd_rresp",  REGS_W'(bus.rresp),  REGS_W'(RESP_OKAY));
    complete_r("mrst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
